// File: rtl/game_flow_ctrl_if.sv
// Mouse, keyboard and game-status bundle between the front-end, game_flow_ctrl and the renderers.
interface game_flow_ctrl_if;
    logic        game_on;
    logic        menu_on;
    logic        game_over;
    logic        victory;
    logic        pause_req;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        opponent_ready;
    logic [2:0]  state;
    logic        play_selected;
    logic        mouse_mode;
    logic        display_buttons_m_and_s;
    logic        display_menu_button;
    logic        player_ready;
    logic        multiplayer;
    logic        countdown_active;
    logic        wait_timeout;

    modport master (
        output game_on, menu_on, game_over, victory, pause_req,
               xpos, ypos, mouse_left, opponent_ready,
        input  state, play_selected, mouse_mode, display_buttons_m_and_s,
               display_menu_button, player_ready, multiplayer,
               countdown_active, wait_timeout
    );

    modport slave (
        input  game_on, menu_on, game_over, victory, pause_req,
               xpos, ypos, mouse_left, opponent_ready,
        output state, play_selected, mouse_mode, display_buttons_m_and_s,
               display_menu_button, player_ready, multiplayer,
               countdown_active, wait_timeout
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Menu/game mode controller: edge-detected clicks, box hit tests, countdown, pause and a
// timed multiplayer wait, with all flags registered alongside the state.
module game_flow_ctrl #(
    parameter int unsigned PLAY_X              = 432,
    parameter int unsigned PLAY_Y              = 400,
    parameter int unsigned PLAY_W              = 128,
    parameter int unsigned PLAY_H              = 80,
    parameter int unsigned MULTI_X             = 432,
    parameter int unsigned MULTI_Y             = 540,
    parameter int unsigned MULTI_W             = 128,
    parameter int unsigned MULTI_H             = 80,
    parameter int unsigned MENU_X              = 432,
    parameter int unsigned MENU_Y              = 520,
    parameter int unsigned MENU_W              = 128,
    parameter int unsigned MENU_H              = 80,
    parameter int unsigned HIT_MARGIN          = 10,
    parameter int unsigned COUNTDOWN_CYCLES    = 195_000_000,
    parameter int unsigned WAIT_TIMEOUT_CYCLES = 1_950_000_000
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  io
);

    typedef enum logic [2:0] {
        MENU       = 3'd0,
        GAME       = 3'd1,
        VICTORY    = 3'd2,
        GAME_OVER  = 3'd3,
        MULTI_WAIT = 3'd4,
        COUNTDOWN  = 3'd5,
        PAUSE      = 3'd6
    } state_t;

    localparam int unsigned CNT_MAX = (COUNTDOWN_CYCLES > WAIT_TIMEOUT_CYCLES) ?
                                      COUNTDOWN_CYCLES : WAIT_TIMEOUT_CYCLES;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] WT_LAST = CNT_W'(WAIT_TIMEOUT_CYCLES - 1);

    // Enlarged box test in 13-bit unsigned space; a negative lower bound clamps to 0.
    function automatic logic in_range(logic [12:0] p, int unsigned org, int unsigned sz);
        logic [12:0] lo;
        logic [12:0] hi;
        lo = (org >= HIT_MARGIN) ? 13'(org - HIT_MARGIN) : 13'd0;
        hi = 13'(org + sz - 1 + HIT_MARGIN);
        return (p >= lo) && (p <= hi);
    endfunction

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             multi_q, multi_nxt;
    logic             mouse_left_p1, pause_req_p1;
    logic             timeout_nxt;

    logic play_selected_q, display_bms_q, display_menu_q, multiplayer_q, countdown_q, wait_timeout_q;
    logic play_selected_d, display_bms_d, display_menu_d, multiplayer_d, countdown_d;

    logic [12:0] x13, y13;
    logic        click, pause_edge;
    logic        in_play, in_multi, in_menu;
    logic        play_click, multi_click, menu_click;

    assign x13 = {1'b0, io.xpos};
    assign y13 = {1'b0, io.ypos};

    assign click      = io.mouse_left & ~mouse_left_p1;
    assign pause_edge = io.pause_req & ~pause_req_p1;

    assign in_play  = in_range(x13, PLAY_X, PLAY_W)   && in_range(y13, PLAY_Y, PLAY_H);
    assign in_multi = in_range(x13, MULTI_X, MULTI_W) && in_range(y13, MULTI_Y, MULTI_H);
    assign in_menu  = in_range(x13, MENU_X, MENU_W)   && in_range(y13, MENU_Y, MENU_H);

    // PLAY wins over MULTI when the enlarged boxes overlap.
    assign play_click  = click & in_play;
    assign multi_click = click & in_multi & ~in_play;
    assign menu_click  = click & in_menu;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= MENU;
            cnt             <= '0;
            multi_q         <= 1'b0;
            mouse_left_p1   <= 1'b0;
            pause_req_p1    <= 1'b0;
            play_selected_q <= 1'b0;
            display_bms_q   <= 1'b1;
            display_menu_q  <= 1'b0;
            multiplayer_q   <= 1'b0;
            countdown_q     <= 1'b0;
            wait_timeout_q  <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            cnt             <= cnt_nxt;
            multi_q         <= multi_nxt;
            mouse_left_p1   <= io.mouse_left;
            pause_req_p1    <= io.pause_req;
            play_selected_q <= play_selected_d;
            display_bms_q   <= display_bms_d;
            display_menu_q  <= display_menu_d;
            multiplayer_q   <= multiplayer_d;
            countdown_q     <= countdown_d;
            wait_timeout_q  <= timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state_q;
        timeout_nxt = 1'b0;
        case (state_q)
            MENU: begin
                if (io.game_on)       state_nxt = COUNTDOWN;
                else if (play_click)  state_nxt = COUNTDOWN;
                else if (multi_click) state_nxt = MULTI_WAIT;
            end
            COUNTDOWN: begin
                if (io.menu_on)         state_nxt = MENU;
                else if (cnt == CD_LAST) state_nxt = GAME;
            end
            GAME: begin
                if (io.menu_on)                   state_nxt = MENU;
                else if (io.game_over)            state_nxt = GAME_OVER;
                else if (io.victory)              state_nxt = VICTORY;
                else if (pause_edge && !multi_q)  state_nxt = PAUSE;
            end
            PAUSE: begin
                if (io.menu_on)      state_nxt = MENU;
                else if (pause_edge) state_nxt = GAME;
            end
            VICTORY, GAME_OVER: begin
                if (io.game_on)       state_nxt = COUNTDOWN;
                else if (io.menu_on)  state_nxt = MENU;
                else if (play_click)  state_nxt = COUNTDOWN;
                else if (multi_click) state_nxt = MULTI_WAIT;
                else if (click)       state_nxt = MENU;
            end
            MULTI_WAIT: begin
                if (io.opponent_ready) state_nxt = COUNTDOWN;
                else if (menu_click)   state_nxt = MENU;
                else if (cnt == WT_LAST) begin
                    state_nxt   = MENU;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = MENU;
        endcase

        if (state_nxt != state_q)
            cnt_nxt = '0;
        else if (state_q == COUNTDOWN || state_q == MULTI_WAIT)
            cnt_nxt = cnt + 1'b1;
        else
            cnt_nxt = '0;

        if (state_nxt == MENU)               multi_nxt = 1'b0;
        else if (play_click || io.game_on)   multi_nxt = 1'b0;
        else if (multi_click)                multi_nxt = 1'b1;
        else                                 multi_nxt = multi_q;
    end

    // Output decode from the upcoming state so flags line up with state
    always_comb begin
        play_selected_d = (state_nxt == GAME);
        display_bms_d   = (state_nxt == MENU) || (state_nxt == VICTORY) || (state_nxt == GAME_OVER);
        display_menu_d  = (state_nxt == MULTI_WAIT);
        countdown_d     = (state_nxt == COUNTDOWN);
        multiplayer_d   = (state_nxt == MULTI_WAIT) ||
                          (multi_nxt && ((state_nxt == COUNTDOWN) || (state_nxt == GAME) ||
                                         (state_nxt == PAUSE)));
    end

    assign io.state                   = state_q;
    assign io.play_selected           = play_selected_q;
    assign io.mouse_mode              = play_selected_q;
    assign io.display_buttons_m_and_s = display_bms_q;
    assign io.display_menu_button     = display_menu_q;
    assign io.player_ready            = display_menu_q;
    assign io.multiplayer             = multiplayer_q;
    assign io.countdown_active        = countdown_q;
    assign io.wait_timeout            = wait_timeout_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scenario bench for game_flow_ctrl with short countdown and wait limits.
module tb_game_flow_ctrl;
    localparam int CD = 4;
    localparam int WT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_flow_ctrl_if ifc();

    game_flow_ctrl #(
        .COUNTDOWN_CYCLES(CD),
        .WAIT_TIMEOUT_CYCLES(WT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic ml, pr, go, mo, gov, vic, opp, r;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] outs;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } step_t;

    step_t tbl[$];
    exp_t  sb[$];
    stim_t cur;
    int    checks = 0;
    int    failures = 0;

    // Expected flags: play_selected, mouse_mode, buttons_m_and_s, menu_button,
    // player_ready, multiplayer, countdown_active, wait_timeout.
    function automatic logic [7:0] dec(logic [2:0] st, logic m, logic to);
        logic [7:0] o;
        o[7] = (st == 3'd1);
        o[6] = (st == 3'd1);
        o[5] = (st == 3'd0) || (st == 3'd2) || (st == 3'd3);
        o[4] = (st == 3'd4);
        o[3] = (st == 3'd4);
        o[2] = (st == 3'd4) || (m && ((st == 3'd1) || (st == 3'd5) || (st == 3'd6)));
        o[1] = (st == 3'd5);
        o[0] = to;
        return o;
    endfunction

    function automatic logic [7:0] act();
        return {ifc.play_selected, ifc.mouse_mode, ifc.display_buttons_m_and_s,
                ifc.display_menu_button, ifc.player_ready, ifc.multiplayer,
                ifc.countdown_active, ifc.wait_timeout};
    endfunction

    task automatic add(logic [2:0] st, logic m, logic to);
        step_t t;
        t.s      = cur;
        t.e.st   = st;
        t.e.outs = dec(st, m, to);
        tbl.push_back(t);
    endtask

    task automatic apply(stim_t s);
        rst                = s.r;
        ifc.xpos           = s.x;
        ifc.ypos           = s.y;
        ifc.mouse_left     = s.ml;
        ifc.pause_req      = s.pr;
        ifc.game_on        = s.go;
        ifc.menu_on        = s.mo;
        ifc.game_over      = s.gov;
        ifc.victory        = s.vic;
        ifc.opponent_ready = s.opp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        cur   = '0;
        cur.r = 1'b1;
        add(3'd0, 1'b0, 1'b0);
        add(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
        checks++;
        if (dut.cnt !== 3'(0)) begin
            failures++;
            $display("FAIL reset_counter: got %0d, expected 0", dut.cnt);
        end
        cur.r = 1'b0;
    endtask

    task automatic test_play_countdown();
        exp_t e, g;
        cur.x = 12'd440;
        cur.y = 12'd410;
        add(3'd0, 1'b0, 1'b0);
        cur.ml = 1'b1;
        add(3'd5, 1'b0, 1'b0);
        cur.ml = 1'b0;
        repeat (CD - 1) add(3'd5, 1'b0, 1'b0);
        add(3'd1, 1'b0, 1'b0);
        add(3'd1, 1'b0, 1'b0);
        cur.mo = 1'b1;
        add(3'd0, 1'b0, 1'b0);
        cur.mo = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL play_countdown step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
    endtask

    task automatic test_held_click_timeout();
        exp_t e, g;
        cur.x  = 12'd440;
        cur.y  = 12'd550;
        cur.ml = 1'b1;
        repeat (WT) add(3'd4, 1'b1, 1'b0);
        add(3'd0, 1'b0, 1'b1);
        repeat (20 - WT - 1) add(3'd0, 1'b0, 1'b0);
        cur.ml = 1'b0;
        add(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL held_click_timeout step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
    endtask

    task automatic test_wait_opponent();
        exp_t e, g;
        cur.ml = 1'b1;
        add(3'd4, 1'b1, 1'b0);
        cur.ml = 1'b0;
        repeat (WT - 1) add(3'd4, 1'b1, 1'b0);
        cur.opp = 1'b1;
        add(3'd5, 1'b1, 1'b0);
        cur.opp = 1'b0;
        repeat (CD - 1) add(3'd5, 1'b1, 1'b0);
        add(3'd1, 1'b1, 1'b0);
        cur.pr = 1'b1;
        add(3'd1, 1'b1, 1'b0);
        cur.pr = 1'b0;
        add(3'd1, 1'b1, 1'b0);
        cur.mo = 1'b1;
        add(3'd0, 1'b0, 1'b0);
        cur.mo = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL wait_opponent step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
    endtask

    task automatic test_pause();
        exp_t e, g;
        cur.x  = 12'd10;
        cur.y  = 12'd10;
        cur.go = 1'b1;
        add(3'd5, 1'b0, 1'b0);
        cur.go = 1'b0;
        repeat (CD - 1) add(3'd5, 1'b0, 1'b0);
        add(3'd1, 1'b0, 1'b0);
        cur.pr = 1'b1;
        add(3'd6, 1'b0, 1'b0);
        add(3'd6, 1'b0, 1'b0);
        cur.pr = 1'b0;
        add(3'd6, 1'b0, 1'b0);
        cur.pr = 1'b1;
        add(3'd1, 1'b0, 1'b0);
        cur.pr = 1'b0;
        add(3'd1, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL pause step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
    endtask

    task automatic test_end_states();
        exp_t e, g;
        cur.gov = 1'b1;
        cur.vic = 1'b1;
        add(3'd3, 1'b0, 1'b0);
        cur.gov = 1'b0;
        cur.vic = 1'b0;
        cur.x   = 12'd10;
        cur.y   = 12'd10;
        cur.ml  = 1'b1;
        add(3'd0, 1'b0, 1'b0);
        cur.ml = 1'b0;
        add(3'd0, 1'b0, 1'b0);
        cur.x  = 12'd421;
        cur.y  = 12'd400;
        cur.ml = 1'b1;
        add(3'd0, 1'b0, 1'b0);
        cur.ml = 1'b0;
        add(3'd0, 1'b0, 1'b0);
        cur.x  = 12'd423;
        cur.y  = 12'd391;
        cur.ml = 1'b1;
        add(3'd5, 1'b0, 1'b0);
        cur.ml = 1'b0;
        add(3'd5, 1'b0, 1'b0);
        add(3'd5, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL end_states step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e, g;
        checks++;
        if (dut.cnt !== 3'(2)) begin
            failures++;
            $display("FAIL mid_counter_before: got %0d, expected 2", dut.cnt);
        end
        cur.r = 1'b1;
        add(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            sb.push_back(tbl[i].e);
            tick();
            e = sb.pop_front();
            g.st = ifc.state;
            g.outs = act();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_mid step %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         i, g.st, g.outs, e.st, e.outs);
            end
        end
        tbl.delete();
        checks++;
        if (dut.cnt !== 3'(0)) begin
            failures++;
            $display("FAIL reset_mid_counter: got %0d, expected 0", dut.cnt);
        end
        cur.r = 1'b0;
        apply(cur);
        tick();
    endtask

    initial begin
        test_reset();
        test_play_countdown();
        test_held_click_timeout();
        test_wait_opponent();
        test_pause();
        test_end_states();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
